sdram_init_responder: RTL and testbench
=======================================

# sdram_init_responder

Device-side counterpart of the SDRAM initialisation sequencer: a synthesizable responder/checker that watches the 4-bit command bus and 13-bit address/mode bus, enforces the SDRAM power-up protocol and inter-command timing, and captures the programmed mode register. It sits on the SDRAM command path in simulation benches and FPGA self-check builds. It reports device readiness, the decoded CAS latency and burst length, and the first protocol violation.

## Interface
- SDRAMMHZ, 100, clock frequency; NSPRESEC = ceil(1000/SDRAMMHZ)
- TPWRNS, 200, power-up NOP time; CYCST = ceil(TPWRNS/NSPRESEC)
- TRPNS, 20, precharge period; CYCRP = ceil(TRPNS/NSPRESEC)
- TRFCNS, 70, refresh period; CYCRFC = ceil(TRFCNS/NSPRESEC)
- TMRDCYC, 2, mode-register-set to next command, in cycles
- REFREQ, 2, auto-refreshes required before MRS
- Clk  in  1  clock
- Rest  in  1  reset; one clock domain; reset is synchronous and active-high
- SdramCmd  in  4  {CS_n,RAS_n,CAS_n,WE_n}
- SdramMode  in  13  address bus, A10 = precharge-all, mode word on MRS
- DevReady  out  1  initialisation complete and no timer running
- ModeReg  out  13  last accepted mode word
- CasLat  out  3  ModeReg[6:4]
- BurstLen  out  3  ModeReg[2:0]
- RefCnt  out  4  auto-refreshes accepted since last precharge-all, saturating at 15
- ErrValid  out  1  one-cycle pulse on first violation
- ErrCode  out  3  first violation code, sticky

## Operation
- Commands: NOPC 0111, PRECHAGE 0010, AUTOREF 0001, MODEREGSET 0000. CS_n=1 (deselect) counts as NOP. Any other encoding is "other".
- Power-up counter PwrCnt (8 bit) counts cycles after reset, saturating at CYCST.
- Timer Tmr (8 bit): loaded with CYC-1 on accepting a timed command, then decrements to 0. A command is allowed only when Tmr==0. A non-NOP while Tmr!=0 gives E_TIMING.
- States and transitions:
  - PWRUP: non-NOP before PwrCnt==CYCST gives E_EARLY. When PwrCnt reaches CYCST, go to WAITPRE.
  - WAITPRE:
    - PRECHAGE with A10=1: Tmr=CYCRP-1, RefCnt=0, go to WAITREF.
    - PRECHAGE with A10=0: E_PREALL.
    - Any other non-NOP: E_SEQ.
  - WAITREF:
    - AUTOREF: RefCnt++, Tmr=CYCRFC-1.
    - MODEREGSET with RefCnt>=REFREQ: mode check. If it passes, capture ModeReg, set Tmr=TMRDCYC-1, go to READY.
    - MODEREGSET with RefCnt<REFREQ: E_SEQ.
    - Any other non-NOP: E_SEQ.
  - READY:
    - PRECHAGE with A10=1: re-init path. Tmr=CYCRP-1, RefCnt=0, go to WAITREF.
    - AUTOREF: Tmr=CYCRFC-1.
    - MODEREGSET: re-check and recapture the mode word.
    - Other commands: ignored, since they belong to the data path.
  - ERROR: entered on any violation. Sticky until Rest; all commands ignored.
- Mode check: CAS latency field must be 2 or 3, BurstLen in {0,1,2,3}, bits [12:10] must be 0. Any failure gives E_MODE and ModeReg is not updated.
- Error codes: E_NONE 0, E_EARLY 1, E_PREALL 2, E_SEQ 3, E_TIMING 4, E_MODE 5.
- Priority when several errors apply on one command: E_EARLY > E_TIMING > E_SEQ/E_PREALL > E_MODE.

## Timing
- Reset values: all outputs 0; state PWRUP; PwrCnt=0; Tmr=0.
- A command sampled at edge t updates state, Tmr and captured outputs at edge t (registered, visible at t+1).
- Next timed command is legal at cycle t+CYC (CYCRP, CYCRFC or TMRDCYC).
- DevReady = (state==READY) && (Tmr==0). It first rises TMRDCYC cycles after the MRS and drops the cycle after an AUTOREF or PRECHAGE is accepted in READY.
- ErrValid is high for exactly the cycle after detection. ErrCode latches in the same cycle and holds until reset.
- Rest asserted mid-sequence returns to PWRUP next edge; outputs clear and PwrCnt restarts.
- RefCnt saturates at 15. AUTOREFs beyond REFREQ are legal.

## Structure
- define.v holds the shared constants:
  - command encodings NOPC/PRECHAGE/AUTOREF/MODEREGSET
  - responder state encodings RS_PWRUP..RS_ERROR
  - error codes E_*
- One sub-module, sdram_cyc_timer: loadable 8-bit down-counter with a zero flag, reused for Tmr.
- All else lives in one FSM process in sdram_init_responder.

## Test plan
- Legal sequence at 100 MHz, driven as follows, gives DevReady=1 at MRS+2, CasLat=2, BurstLen=0, ErrCode=0:
  - 21 NOP
  - PRECHAGE A10=1
  - NOP x2
  - AUTOREF, NOP x6
  - AUTOREF, NOP x6
  - MODEREGSET 0x020
- PRECHAGE at cycle 5 after reset -> ErrValid pulse, ErrCode=1, state ERROR, DevReady stays 0.
- Second AUTOREF 3 cycles after the first -> ErrCode=4. A later legal MRS is ignored, ModeReg=0.
- MRS after a single AUTOREF -> ErrCode=3. PRECHAGE with A10=0 in WAITPRE -> ErrCode=2.
- MODEREGSET 0x070 (CAS=7) -> ErrCode=5, ModeReg unchanged.
- After READY, PRECHAGE A10=1 then 2 AUTOREF and MRS 0x031:
  - DevReady drops, then returns high.
  - CasLat=3, BurstLen=1.
  - Rest pulse mid-WAITREF returns all outputs to 0.

Source files
------------

// File: rtl/sdram_init_responder_pkg.sv
// Shared constants for the SDRAM initialisation responder: command encodings,
// responder states, violation codes and small decode/check helpers.
package sdram_init_responder_pkg;

  typedef enum logic [2:0] {
    RS_PWRUP   = 3'd0,
    RS_WAITPRE = 3'd1,
    RS_WAITREF = 3'd2,
    RS_READY   = 3'd3,
    RS_ERROR   = 3'd4
  } rs_state_e;

  typedef enum logic [2:0] {
    CK_NOP   = 3'd0,
    CK_PRE   = 3'd1,
    CK_REF   = 3'd2,
    CK_MRS   = 3'd3,
    CK_OTHER = 3'd4
  } cmd_kind_e;

  localparam logic [3:0] NOPC       = 4'b0111;
  localparam logic [3:0] PRECHAGE   = 4'b0010;
  localparam logic [3:0] AUTOREF    = 4'b0001;
  localparam logic [3:0] MODEREGSET = 4'b0000;

  localparam logic [2:0] E_NONE   = 3'd0;
  localparam logic [2:0] E_EARLY  = 3'd1;
  localparam logic [2:0] E_PREALL = 3'd2;
  localparam logic [2:0] E_SEQ    = 3'd3;
  localparam logic [2:0] E_TIMING = 3'd4;
  localparam logic [2:0] E_MODE   = 3'd5;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

  // CS_n high is a deselect and behaves exactly like a NOP.
  function automatic cmd_kind_e decode_cmd(input logic [3:0] cmd);
    cmd_kind_e kind;
    if (cmd[3]) begin
      kind = CK_NOP;
    end else begin
      case (cmd)
        NOPC:       kind = CK_NOP;
        PRECHAGE:   kind = CK_PRE;
        AUTOREF:    kind = CK_REF;
        MODEREGSET: kind = CK_MRS;
        default:    kind = CK_OTHER;
      endcase
    end
    return kind;
  endfunction

  function automatic logic mode_ok(input logic [12:0] mode);
    return (mode[12:10] == 3'd0) &&
           ((mode[6:4] == 3'd2) || (mode[6:4] == 3'd3)) &&
           (mode[2] == 1'b0);
  endfunction

endpackage

// File: rtl/sdram_init_responder_cyc_timer.sv
// Loadable 8-bit down-counter with a zero flag; holds at zero until reloaded.
module sdram_init_responder_cyc_timer (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_load,
  input  logic [7:0] i_load_val,
  output logic [7:0] o_count,
  output logic       o_zero
);

  logic [7:0] r_count;

  // Load takes precedence over the decrement so back-to-back timed commands restart the window.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= 8'd0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != 8'd0) begin
      r_count <= r_count - 8'd1;
    end
  end

  assign o_count = r_count;
  assign o_zero  = (r_count == 8'd0);

endmodule

// File: rtl/sdram_init_responder.sv
// SDRAM power-up protocol checker: tracks the init sequence on the command bus,
// enforces inter-command timing, captures the mode word and reports the first violation.
module sdram_init_responder
  import sdram_init_responder_pkg::*;
#(
  parameter int SDRAMMHZ = 100,
  parameter int TPWRNS   = 200,
  parameter int TRPNS    = 20,
  parameter int TRFCNS   = 70,
  parameter int TMRDCYC  = 2,
  parameter int REFREQ   = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [3:0]  i_sdram_cmd,
  input  logic [12:0] i_sdram_mode,
  output logic        o_dev_ready,
  output logic [12:0] o_mode_reg,
  output logic [2:0]  o_cas_lat,
  output logic [2:0]  o_burst_len,
  output logic [3:0]  o_ref_cnt,
  output logic        o_err_valid,
  output logic [2:0]  o_err_code
);

  localparam int NSPRESEC = ceil_div(1000, SDRAMMHZ);
  localparam int CYCST    = ceil_div(TPWRNS, NSPRESEC);
  localparam int CYCRP    = ceil_div(TRPNS, NSPRESEC);
  localparam int CYCRFC   = ceil_div(TRFCNS, NSPRESEC);

  localparam logic [7:0] PWR_DONE = 8'(CYCST);
  localparam logic [7:0] PWR_LAST = 8'(CYCST - 1);
  localparam logic [7:0] LD_RP    = 8'(CYCRP - 1);
  localparam logic [7:0] LD_RFC   = 8'(CYCRFC - 1);
  localparam logic [7:0] LD_MRD   = 8'(TMRDCYC - 1);
  localparam logic [3:0] REF_REQ  = 4'(REFREQ);

  rs_state_e   r_state;
  logic [7:0]  r_pwr_cnt;
  logic [3:0]  r_ref_cnt;
  logic [12:0] r_mode_reg;
  logic        r_dev_ready;
  logic        r_err_valid;
  logic [2:0]  r_err_code;

  cmd_kind_e   w_kind;
  logic        w_a10;
  logic        w_mode_ok;
  logic        w_refs_done;
  logic [7:0]  w_tmr;
  logic        w_tmr_zero;
  logic        w_tmr_zero_next;
  logic        w_enter_ready;
  logic [2:0]  w_err;
  logic        w_load;
  logic [7:0]  w_load_val;

  assign w_kind      = decode_cmd(i_sdram_cmd);
  assign w_a10       = i_sdram_mode[10];
  assign w_mode_ok   = mode_ok(i_sdram_mode);
  assign w_refs_done = (r_ref_cnt >= REF_REQ);

  sdram_init_responder_cyc_timer u_tmr (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_count    (w_tmr),
    .o_zero     (w_tmr_zero)
  );

  // Classify the sampled command: violation code in priority order, or timer load if accepted.
  always_comb begin
    w_err      = E_NONE;
    w_load     = 1'b0;
    w_load_val = 8'd0;
    if ((w_kind == CK_NOP) || (r_state == RS_ERROR)) begin
      w_err = E_NONE;
    end else if (r_state == RS_PWRUP) begin
      w_err = E_EARLY;
    end else if (!w_tmr_zero) begin
      w_err = E_TIMING;
    end else begin
      case (r_state)
        RS_WAITPRE: begin
          if ((w_kind == CK_PRE) && w_a10) begin
            w_load     = 1'b1;
            w_load_val = LD_RP;
          end else if (w_kind == CK_PRE) begin
            w_err = E_PREALL;
          end else begin
            w_err = E_SEQ;
          end
        end
        RS_WAITREF: begin
          if (w_kind == CK_REF) begin
            w_load     = 1'b1;
            w_load_val = LD_RFC;
          end else if ((w_kind == CK_MRS) && w_refs_done && w_mode_ok) begin
            w_load     = 1'b1;
            w_load_val = LD_MRD;
          end else if ((w_kind == CK_MRS) && w_refs_done) begin
            w_err = E_MODE;
          end else begin
            w_err = E_SEQ;
          end
        end
        RS_READY: begin
          if ((w_kind == CK_PRE) && w_a10) begin
            w_load     = 1'b1;
            w_load_val = LD_RP;
          end else if (w_kind == CK_REF) begin
            w_load     = 1'b1;
            w_load_val = LD_RFC;
          end else if ((w_kind == CK_MRS) && w_mode_ok) begin
            w_load     = 1'b1;
            w_load_val = LD_MRD;
          end else if (w_kind == CK_MRS) begin
            w_err = E_MODE;
          end else begin
            w_err = E_NONE;
          end
        end
        default: w_err = E_NONE;
      endcase
    end
  end

  assign w_tmr_zero_next = w_load ? (w_load_val == 8'd0) : (w_tmr <= 8'd1);
  assign w_enter_ready   = (w_err == E_NONE) &&
                           ((r_state == RS_READY) ||
                            ((r_state == RS_WAITREF) && (w_kind == CK_MRS) && w_load));

  // Responder FSM; once a violation is seen everything freezes until reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= RS_PWRUP;
      r_pwr_cnt   <= 8'd0;
      r_ref_cnt   <= 4'd0;
      r_mode_reg  <= 13'd0;
      r_dev_ready <= 1'b0;
      r_err_valid <= 1'b0;
      r_err_code  <= E_NONE;
    end else begin
      r_err_valid <= 1'b0;
      r_dev_ready <= w_enter_ready && w_tmr_zero_next;
      if (r_pwr_cnt != PWR_DONE) begin
        r_pwr_cnt <= r_pwr_cnt + 8'd1;
      end
      if (w_err != E_NONE) begin
        r_state     <= RS_ERROR;
        r_err_valid <= 1'b1;
        r_err_code  <= w_err;
      end else begin
        case (r_state)
          RS_PWRUP: begin
            if (r_pwr_cnt >= PWR_LAST) begin
              r_state <= RS_WAITPRE;
            end
          end
          RS_WAITPRE: begin
            if (w_load) begin
              r_state   <= RS_WAITREF;
              r_ref_cnt <= 4'd0;
            end
          end
          RS_WAITREF, RS_READY: begin
            if (w_load && (w_kind == CK_PRE)) begin
              r_state   <= RS_WAITREF;
              r_ref_cnt <= 4'd0;
            end else if (w_load && (w_kind == CK_REF)) begin
              if (r_ref_cnt != 4'hF) begin
                r_ref_cnt <= r_ref_cnt + 4'd1;
              end
            end else if (w_load && (w_kind == CK_MRS)) begin
              r_mode_reg <= i_sdram_mode;
              r_state    <= RS_READY;
            end
          end
          default: r_state <= r_state;
        endcase
      end
    end
  end

  assign o_dev_ready = r_dev_ready;
  assign o_mode_reg  = r_mode_reg;
  assign o_cas_lat   = r_mode_reg[6:4];
  assign o_burst_len = r_mode_reg[2:0];
  assign o_ref_cnt   = r_ref_cnt;
  assign o_err_valid = r_err_valid;
  assign o_err_code  = r_err_code;

endmodule

// File: tb/tb_sdram_init_responder.sv
// Self-checking bench for sdram_init_responder: directed protocol scenarios plus
// randomized command streams compared against a rule-level reference model.
module tb_sdram_init_responder;

  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_REF = 4'b0001;
  localparam logic [3:0] C_MRS = 4'b0000;
  localparam int CYCST  = 20;
  localparam int CYCRP  = 2;
  localparam int CYCRFC = 7;
  localparam int CYCMRD = 2;
  localparam int REFREQ = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  cmd = 4'b0111;
  logic [12:0] mode = 13'd0;
  logic        dev_ready;
  logic [12:0] mode_reg;
  logic [2:0]  cas_lat;
  logic [2:0]  burst_len;
  logic [3:0]  ref_cnt;
  logic        err_valid;
  logic [2:0]  err_code;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: rules of the protocol expressed as flags and a "next legal cycle".
  int m_k, m_next, m_refs, m_mode, m_err;
  bit m_pre, m_ready, m_errv;

  sdram_init_responder dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_sdram_cmd  (cmd),
    .i_sdram_mode (mode),
    .o_dev_ready  (dev_ready),
    .o_mode_reg   (mode_reg),
    .o_cas_lat    (cas_lat),
    .o_burst_len  (burst_len),
    .o_ref_cnt    (ref_cnt),
    .o_err_valid  (err_valid),
    .o_err_code   (err_code)
  );

  always #5 clk = ~clk;

  function automatic bit exp_ready();
    return (m_err == 0) && m_ready && (m_k >= m_next);
  endfunction

  task automatic model_cmd(input logic [3:0] c, input logic [12:0] a);
    int av, cas, bl, hi;
    bit nop, ok;
    av  = int'(a);
    cas = (av / 16) % 8;
    bl  = av % 8;
    hi  = av / 1024;
    ok  = ((cas == 2) || (cas == 3)) && (bl <= 3) && (hi == 0);
    nop = (c[3] == 1'b1) || (c == C_NOP);
    m_errv = 1'b0;
    if ((m_err == 0) && !nop) begin
      if (m_k < CYCST) begin
        m_err = 1; m_errv = 1'b1;
      end else if (m_k < m_next) begin
        m_err = 4; m_errv = 1'b1;
      end else if (!m_pre) begin
        if ((c == C_PRE) && a[10]) begin
          m_pre = 1'b1; m_refs = 0; m_next = m_k + CYCRP;
        end else begin
          m_err = (c == C_PRE) ? 2 : 3; m_errv = 1'b1;
        end
      end else if (!m_ready) begin
        if (c == C_REF) begin
          if (m_refs < 15) m_refs++;
          m_next = m_k + CYCRFC;
        end else if ((c == C_MRS) && (m_refs >= REFREQ)) begin
          if (ok) begin
            m_mode = av; m_ready = 1'b1; m_next = m_k + CYCMRD;
          end else begin
            m_err = 5; m_errv = 1'b1;
          end
        end else begin
          m_err = 3; m_errv = 1'b1;
        end
      end else begin
        if ((c == C_PRE) && a[10]) begin
          m_ready = 1'b0; m_refs = 0; m_next = m_k + CYCRP;
        end else if (c == C_REF) begin
          if (m_refs < 15) m_refs++;
          m_next = m_k + CYCRFC;
        end else if (c == C_MRS) begin
          if (ok) begin
            m_mode = av; m_next = m_k + CYCMRD;
          end else begin
            m_err = 5; m_errv = 1'b1;
          end
        end
      end
    end
    m_k++;
  endtask

  task automatic step(input logic [3:0] c, input logic [12:0] a);
    cmd  = c;
    mode = a;
    @(posedge clk);
    model_cmd(c, a);
    #1;
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) step(C_NOP, 13'd0);
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    cmd  = C_NOP;
    mode = 13'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    m_k = 0; m_next = 0; m_refs = 0; m_mode = 0; m_err = 0;
    m_pre = 1'b0; m_ready = 1'b0; m_errv = 1'b0;
  endtask

  task automatic legal_init(input logic [12:0] mrs_word);
    nops(21);
    step(C_PRE, 13'h400);
    nops(2);
    step(C_REF, 13'd0);
    nops(6);
    step(C_REF, 13'd0);
    nops(6);
    step(C_MRS, mrs_word);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({dev_ready, err_valid, err_code} !== 5'd0) $display("FAIL reset_flags: got %b want 00000", {dev_ready, err_valid, err_code});
    else n_pass++;
    n_checks++;
    if (mode_reg !== 13'd0) $display("FAIL reset_mode_reg: got %h want 0000", mode_reg);
    else n_pass++;
    n_checks++;
    if ({ref_cnt, cas_lat, burst_len} !== 10'd0) $display("FAIL reset_counts: got %b want 0", {ref_cnt, cas_lat, burst_len});
    else n_pass++;
  endtask

  task automatic test_legal_sequence();
    do_reset();
    legal_init(13'h020);
    n_checks++;
    if (dev_ready !== 1'b0) $display("FAIL legal_ready_mrs1: got %b want 0", dev_ready);
    else n_pass++;
    step(C_NOP, 13'd0);
    n_checks++;
    if (dev_ready !== 1'b1) $display("FAIL legal_ready_mrs2: got %b want 1", dev_ready);
    else n_pass++;
    n_checks++;
    if ({cas_lat, burst_len, err_code} !== {3'd2, 3'd0, 3'd0}) $display("FAIL legal_fields: got cas=%0d bl=%0d err=%0d want 2 0 0", cas_lat, burst_len, err_code);
    else n_pass++;
    n_checks++;
    if (ref_cnt !== 4'd2) $display("FAIL legal_refcnt: got %0d want 2", ref_cnt);
    else n_pass++;
  endtask

  task automatic test_early();
    do_reset();
    nops(5);
    step(C_PRE, 13'h400);
    n_checks++;
    if ({err_valid, err_code} !== {1'b1, 3'd1}) $display("FAIL early_err: got v=%b code=%0d want v=1 code=1", err_valid, err_code);
    else n_pass++;
    nops(30);
    step(C_PRE, 13'h400);
    n_checks++;
    if ({err_valid, err_code, dev_ready} !== {1'b0, 3'd1, 1'b0}) $display("FAIL early_sticky: got v=%b code=%0d rdy=%b want 0 1 0", err_valid, err_code, dev_ready);
    else n_pass++;
  endtask

  task automatic test_timing();
    do_reset();
    nops(21);
    step(C_PRE, 13'h400);
    nops(2);
    step(C_REF, 13'd0);
    nops(2);
    step(C_REF, 13'd0);
    n_checks++;
    if ({err_valid, err_code} !== {1'b1, 3'd4}) $display("FAIL timing_err: got v=%b code=%0d want v=1 code=4", err_valid, err_code);
    else n_pass++;
    nops(10);
    step(C_MRS, 13'h020);
    nops(3);
    n_checks++;
    if ({mode_reg, err_code, dev_ready} !== {13'd0, 3'd4, 1'b0}) $display("FAIL timing_ignore: got mode=%h code=%0d rdy=%b want 0000 4 0", mode_reg, err_code, dev_ready);
    else n_pass++;
  endtask

  task automatic test_seq_preall();
    do_reset();
    nops(21);
    step(C_PRE, 13'h400);
    nops(2);
    step(C_REF, 13'd0);
    nops(6);
    step(C_MRS, 13'h020);
    n_checks++;
    if ({err_valid, err_code} !== {1'b1, 3'd3}) $display("FAIL seq_err: got v=%b code=%0d want v=1 code=3", err_valid, err_code);
    else n_pass++;
    do_reset();
    nops(21);
    step(C_PRE, 13'h000);
    n_checks++;
    if ({err_valid, err_code} !== {1'b1, 3'd2}) $display("FAIL preall_err: got v=%b code=%0d want v=1 code=2", err_valid, err_code);
    else n_pass++;
  endtask

  task automatic test_mode_check();
    do_reset();
    legal_init(13'h070);
    n_checks++;
    if ({err_valid, err_code, mode_reg} !== {1'b1, 3'd5, 13'd0}) $display("FAIL mode_err: got v=%b code=%0d mode=%h want 1 5 0000", err_valid, err_code, mode_reg);
    else n_pass++;
  endtask

  task automatic test_reinit();
    do_reset();
    legal_init(13'h020);
    step(C_NOP, 13'd0);
    step(C_PRE, 13'h400);
    n_checks++;
    if ({dev_ready, ref_cnt} !== {1'b0, 4'd0}) $display("FAIL reinit_drop: got rdy=%b ref=%0d want 0 0", dev_ready, ref_cnt);
    else n_pass++;
    nops(2);
    step(C_REF, 13'd0);
    nops(6);
    step(C_REF, 13'd0);
    nops(6);
    step(C_MRS, 13'h031);
    step(C_NOP, 13'd0);
    n_checks++;
    if ({dev_ready, cas_lat, burst_len, err_code} !== {1'b1, 3'd3, 3'd1, 3'd0}) $display("FAIL reinit_back: got rdy=%b cas=%0d bl=%0d err=%0d want 1 3 1 0", dev_ready, cas_lat, burst_len, err_code);
    else n_pass++;
    step(C_PRE, 13'h400);
    nops(2);
    step(C_REF, 13'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if ({dev_ready, mode_reg, ref_cnt, err_valid, err_code} !== 22'd0) $display("FAIL reinit_rest: got rdy=%b mode=%h ref=%0d v=%b code=%0d want all 0", dev_ready, mode_reg, ref_cnt, err_valid, err_code);
    else n_pass++;
    do_reset();
  endtask

  task automatic test_random();
    logic [3:0]  c;
    logic [12:0] a;
    int thr, r;
    for (int t = 0; t < 24; t++) begin
      do_reset();
      for (int i = 0; i < 110; i++) begin
        c   = C_NOP;
        a   = 13'($urandom);
        thr = (m_k < CYCST) ? 1 : 30;
        if ($urandom_range(0, 99) < thr) begin
          r = $urandom_range(0, 99);
          if ((r < 80) && (m_k >= m_next) && (m_k >= CYCST)) begin
            a = {3'b000, 3'($urandom), (($urandom_range(0, 1) == 0) ? 3'd2 : 3'd3), 1'($urandom), 3'($urandom_range(0, 3))};
            if ($urandom_range(0, 99) < 15) a = 13'($urandom);
            if (!m_pre) begin
              c = C_PRE;
              a[10] = ($urandom_range(0, 9) != 0);
            end else if (!m_ready) begin
              c = ((m_refs < REFREQ) || ($urandom_range(0, 9) < 3)) ? C_REF : C_MRS;
            end else begin
              case ($urandom_range(0, 3))
                0: begin c = C_PRE; a[10] = 1'b1; end
                1: c = C_REF;
                2: c = C_MRS;
                default: c = 4'($urandom_range(3, 6));
              endcase
            end
          end else begin
            c = 4'($urandom);
          end
        end
        step(c, a);
        n_checks++;
        if ({err_valid, err_code} !== {m_errv, m_err[2:0]}) $display("FAIL rnd_err t=%0d k=%0d: got v=%b code=%0d want v=%b code=%0d", t, m_k, err_valid, err_code, m_errv, m_err);
        else n_pass++;
        n_checks++;
        if (dev_ready !== exp_ready()) $display("FAIL rnd_ready t=%0d k=%0d: got %b want %b", t, m_k, dev_ready, exp_ready());
        else n_pass++;
        n_checks++;
        if ({mode_reg, cas_lat, burst_len} !== {m_mode[12:0], 3'((m_mode / 16) % 8), 3'(m_mode % 8)}) $display("FAIL rnd_mode t=%0d k=%0d: got %h want %h", t, m_k, mode_reg, m_mode);
        else n_pass++;
        n_checks++;
        if (ref_cnt !== m_refs[3:0]) $display("FAIL rnd_refcnt t=%0d k=%0d: got %0d want %0d", t, m_k, ref_cnt, m_refs);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_legal_sequence();
    test_early();
    test_timing();
    test_seq_preall();
    test_mode_check();
    test_reinit();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
